// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter: FSM states and the
// {op,select} command encodings understood by Memory_unit.
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Encoded as {op, select}.
   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b11;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick; the last-grant pointer lives in the caller.
module rr_arbiter_2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic pick
);

   always_comb begin
      valid = req0 | req1;
      pick  = req1;
      // On a tie the client that was not granted last time wins.
      if (req0 && req1) begin
         pick = ~last;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin controller letting two clients share one Memory_unit; every
// transaction is a single word, held on the command lines for a fixed count.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int ADR_W     = 3,
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [ADR_W-1:0] adr0,
   input  logic [ADR_W-1:0] adr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic             busy,
   output logic             mem_op,
   output logic             mem_select,
   output logic [ADR_W-1:0] mem_adr,
   output logic [WIDTH-1:0] mem_in,
   input  logic [WIDTH-1:0] mem_out
);

   localparam int CNT_W = $clog2(max2(WR_CYCLES, RD_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             we_q, we_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cmd_q, cmd_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic             any_req, pick, sel_we;

   rr_arbiter_2 u_arb (
      .req0  (req0),
      .req1  (req1),
      .last  (last_q),
      .valid (any_req),
      .pick  (pick)
   );

   assign sel_we = pick ? we1 : we0;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      adr_d    = adr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      cmd_d    = CMD_IDLE;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = pick;
               last_d  = pick;
               we_d    = sel_we;
               adr_d   = pick ? adr1 : adr0;
               wdata_d = pick ? wdata1 : wdata0;
               cnt_d   = sel_we ? WR_LOAD : RD_LOAD;
               cmd_d   = sel_we ? CMD_WRITE : CMD_READ;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cmd_d = we_q ? CMD_WRITE : CMD_READ;
            if (cnt_q == '0) begin
               // Last hold cycle: capture read data and release the memory.
               cmd_d   = CMD_IDLE;
               done0_d = ~owner_q;
               done1_d = owner_q;
               if (!we_q) begin
                  if (owner_q) rdata1_d = mem_out;
                  else         rdata0_d = mem_out;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         cmd_q    <= CMD_IDLE;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign {mem_op, mem_select} = cmd_q;
   assign mem_adr = adr_q;
   assign mem_in  = wdata_q;
   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
